mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one external memory channel between NUM_REQ requesters (fetchers/LSUs
//  or per-core memory controllers). Same valid/ready request interface as the consumer side of the
//  memory controller. Fair rotating priority, one outstanding transaction, watchdog timeout flag.
// PARAMETERS
//  ADDR_BITS      8   address width
//  DATA_BITS      16  data width
//  NUM_REQ        4   number of requesters (>=2)
//  WRITE_ENABLE   1   0: write requests ignored, all write outputs held 0
//  TIMEOUT_CYCLES 0   max cycles waiting on memory ready; 0 disables watchdog
// PORTS
//  clk              in   1                  clock, rising edge
//  reset            in   1                  asynchronous, active-high
//  req_read_valid   in   NUM_REQ            read request per requester
//  req_read_address in   ADDR_BITS[NUM_REQ] read address
//  req_read_ready   out  NUM_REQ            read response valid
//  req_read_data    out  DATA_BITS[NUM_REQ] read data
//  req_write_valid  in   NUM_REQ            write request
//  req_write_address in  ADDR_BITS[NUM_REQ] write address
//  req_write_data   in   DATA_BITS[NUM_REQ] write data
//  req_write_ready  out  NUM_REQ            write done
//  mem_read_valid   out  1 / mem_read_address out ADDR_BITS / mem_read_ready in 1 / mem_read_data in DATA_BITS
//  mem_write_valid  out  1 / mem_write_address out ADDR_BITS / mem_write_data out DATA_BITS / mem_write_ready in 1
//  grant_id         out  clog2(NUM_REQ)     requester currently served
//  busy             out  1                  high in any state but IDLE
//  timeout_err      out  1                  sticky; set on watchdog expiry
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, rr_ptr=0, wait counter 0, timeout_err 0.
//  States: IDLE, READ_WAIT, WRITE_WAIT, RELAY. All outputs registered.
//  IDLE: scan k=0..NUM_REQ-1, j=(rr_ptr+k) mod NUM_REQ; first j with read_valid|write_valid wins.
//   Same j with both: read wins. On grant: latch address/data, grant_id<=j, rr_ptr<=(j+1) mod NUM_REQ,
//   assert mem_read_valid or mem_write_valid next cycle, go READ_WAIT/WRITE_WAIT. No request: stay.
//  Latency: req valid in cycle t (IDLE) -> mem valid in t+1. mem ready in cycle k -> req ready in k+1.
//  READ_WAIT: on mem_read_ready: mem_read_valid<=0, req_read_data[j]<=mem_read_data,
//   req_read_ready[j]<=1 -> RELAY. WRITE_WAIT likewise with req_write_ready[j] -> RELAY.
//  Address/data held constant on mem port for the whole wait; requester changes are ignored.
//  Watchdog (TIMEOUT_CYCLES>0): counter clears on grant, +1 per wait cycle without ready; when it
//   reaches TIMEOUT_CYCLES: drop mem valid, timeout_err<=1, complete to requester with ready=1 and
//   read data 0 -> RELAY. Counter saturates; never wraps.
//  RELAY: hold ready/data until requester deasserts the valid it was granted on; then ready<=0,
//   -> IDLE. Next grant evaluated in the IDLE cycle, so minimum 1 dead cycle between transactions.
//  Ready never asserted to a non-granted requester; at most one of mem_read_valid/mem_write_valid high.
//  Requester dropping valid mid-wait: transaction still completes; ready pulses for 1 cycle in RELAY.
//  WRITE_ENABLE=0: req_write_valid never wins; req_write_ready and mem_write_* stay 0.
//  req_read_data[j] holds last value after ready drops. timeout_err clears only on reset.
//  Reset mid-transaction: immediate return to reset values; in-flight request discarded.
// TESTING
//  Single read: req0 read addr 0x12, mem returns 0xBEEF after 3 cycles -> req_read_data[0]=0xBEEF,
//   ready one cycle after mem ready, grant_id=0, mem_read_valid low after ready.
//  Fairness: all 4 requesters hold read_valid -> grant order 0,1,2,3,0 with rr_ptr rotating; none starved.
//  Same requester read+write both valid -> read served first, write next round; write addr 0x40
//   data 0x1234 appears unchanged on mem_write_* until mem_write_ready.
//  TIMEOUT_CYCLES=5, memory never ready -> after 5 wait cycles timeout_err=1, req_read_ready=1,
//   data 0; a following request is still served normally and timeout_err stays 1.
//  WRITE_ENABLE=0, req1 write_valid only -> no mem activity, busy stays 0, req_write_ready stays 0.
//  Assert reset while in READ_WAIT -> all outputs 0 immediately (async), next grant starts at req0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one memory channel among NUM_REQ requesters
module mem_rr_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_REQ        = 4,
  parameter int WRITE_ENABLE   = 1,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int ID_BITS       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_read_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_read_address,
  output logic [NUM_REQ-1:0]             req_read_ready,
  output logic [NUM_REQ*DATA_BITS-1:0]   req_read_data,
  input  logic [NUM_REQ-1:0]             req_write_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_write_address,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_write_data,
  output logic [NUM_REQ-1:0]             req_write_ready,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_address,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic [ID_BITS-1:0]             grant_id,
  output logic                           busy,
  output logic                           timeout_err
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
  state_t state, state_d;
  logic [ID_BITS-1:0] rr_ptr, rr_ptr_d, grant_id_d, pick, j;
  logic relay_wr, relay_wr_d, found, pick_wr, done, tmo;
  logic [CW-1:0] wait_cnt, wait_cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] wr_req, req_read_ready_d, req_write_ready_d;
  logic [NUM_REQ*DATA_BITS-1:0] req_read_data_d;
  logic mem_read_valid_d, mem_write_valid_d, timeout_err_d;
  logic [ADDR_BITS-1:0] mem_read_address_d, mem_write_address_d;
  logic [DATA_BITS-1:0] mem_write_data_d;
  assign wr_req  = (WRITE_ENABLE != 0) ? req_write_valid : '0;
  assign cnt_inc = (wait_cnt == TMAX) ? wait_cnt : wait_cnt + 1'b1;
  assign tmo     = (TIMEOUT_CYCLES > 0) && (cnt_inc == TMAX);
  // next-state and next-output computation; every output is registered below
  always_comb begin
    state_d = state;
    rr_ptr_d = rr_ptr;
    grant_id_d = grant_id;
    relay_wr_d = relay_wr;
    wait_cnt_d = wait_cnt;
    timeout_err_d = timeout_err;
    mem_read_valid_d = mem_read_valid;
    mem_write_valid_d = mem_write_valid;
    mem_read_address_d = mem_read_address;
    mem_write_address_d = mem_write_address;
    mem_write_data_d = mem_write_data;
    req_read_ready_d = req_read_ready;
    req_write_ready_d = req_write_ready;
    req_read_data_d = req_read_data;
    found = 1'b0;
    pick = '0;
    pick_wr = 1'b0;
    j = '0;
    done = relay_wr ? mem_write_ready : mem_read_ready;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = ID_BITS'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && (req_read_valid[j] || wr_req[j])) begin
        found = 1'b1;
        pick = j;
        pick_wr = !req_read_valid[j];
      end
    end
    case (state)
      IDLE: if (found) begin
        grant_id_d = pick;
        rr_ptr_d = (pick == ID_BITS'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
        relay_wr_d = pick_wr;
        wait_cnt_d = '0;
        if (pick_wr) begin
          mem_write_valid_d = 1'b1;
          mem_write_address_d = req_write_address[pick*ADDR_BITS +: ADDR_BITS];
          mem_write_data_d = req_write_data[pick*DATA_BITS +: DATA_BITS];
          state_d = WRITE_WAIT;
        end else begin
          mem_read_valid_d = 1'b1;
          mem_read_address_d = req_read_address[pick*ADDR_BITS +: ADDR_BITS];
          state_d = READ_WAIT;
        end
      end
      READ_WAIT, WRITE_WAIT: if (done || tmo) begin
        mem_read_valid_d = 1'b0;
        mem_write_valid_d = 1'b0;
        timeout_err_d = timeout_err | !done;
        state_d = RELAY;
        if (relay_wr) req_write_ready_d[grant_id] = 1'b1;
        else begin
          req_read_ready_d[grant_id] = 1'b1;
          req_read_data_d[grant_id*DATA_BITS +: DATA_BITS] = done ? mem_read_data : '0;
        end
      end else wait_cnt_d = cnt_inc;
      default: if (!(relay_wr ? req_write_valid[grant_id] : req_read_valid[grant_id])) begin
        req_read_ready_d = '0;
        req_write_ready_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  // state and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      relay_wr <= 1'b0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      busy <= 1'b0;
      mem_read_valid <= 1'b0;
      mem_write_valid <= 1'b0;
      mem_read_address <= '0;
      mem_write_address <= '0;
      mem_write_data <= '0;
      req_read_ready <= '0;
      req_write_ready <= '0;
      req_read_data <= '0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_ptr_d;
      grant_id <= grant_id_d;
      relay_wr <= relay_wr_d;
      wait_cnt <= wait_cnt_d;
      timeout_err <= timeout_err_d;
      busy <= state_d != IDLE;
      mem_read_valid <= mem_read_valid_d;
      mem_write_valid <= mem_write_valid_d;
      mem_read_address <= mem_read_address_d;
      mem_write_address <= mem_write_address_d;
      mem_write_data <= mem_write_data_d;
      req_read_ready <= req_read_ready_d;
      req_write_ready <= req_write_ready_d;
      req_read_data <= req_read_data_d;
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench for mem_rr_arbiter with a latency-programmable memory model
module tb_mem_rr_arbiter;
  typedef struct {int id; bit wr; logic [7:0] addr; logic [15:0] wdata;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] rv = '0, wv = '0, rrdy, wrdy;
  logic [31:0] ra = '0, wa = '0;
  logic [63:0] wd = '0, rdata;
  logic mrv, mwv, mrr = 1'b0, mwr = 1'b0, busy, terr;
  logic [7:0] mra, mwa;
  logic [15:0] mrd = '0, mwd;
  logic [1:0] gid;
  logic [3:0] b_rv = '0, b_wv = '0, b_rrdy, b_wrdy;
  logic [31:0] b_ra = '0, b_wa = '0;
  logic [63:0] b_wd = '0, b_rdata;
  logic b_mrv, b_mwv, b_busy, b_terr, b_mrr = 1'b0, b_mwr = 1'b0;
  logic [7:0] b_mra, b_mwa;
  logic [15:0] b_mrd = '0, b_mwd;
  logic [1:0] b_gid;
  int checks = 0, failures = 0, mem_lat = 3, mcnt = 0, n;
  int lg[4], ld[4];
  bit mem_en = 1'b1, mv_q = 1'b0;
  exp_t exp_q[$];
  exp_t cur;

  mem_rr_arbiter #(.TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .reset(reset),
    .req_read_valid(rv), .req_read_address(ra), .req_read_ready(rrdy), .req_read_data(rdata),
    .req_write_valid(wv), .req_write_address(wa), .req_write_data(wd), .req_write_ready(wrdy),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr),
    .grant_id(gid), .busy(busy), .timeout_err(terr));

  mem_rr_arbiter #(.WRITE_ENABLE(0)) dut_nowr (
    .clk(clk), .reset(reset),
    .req_read_valid(b_rv), .req_read_address(b_ra), .req_read_ready(b_rrdy), .req_read_data(b_rdata),
    .req_write_valid(b_wv), .req_write_address(b_wa), .req_write_data(b_wd), .req_write_ready(b_wrdy),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra), .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
    .grant_id(b_gid), .busy(b_busy), .timeout_err(b_terr));

  function automatic logic [15:0] mem_fn(input logic [7:0] a);
    return (a == 8'h12) ? 16'hBEEF : {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input bit wr, input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back('{id: id, wr: wr, addr: a, wdata: d});
  endtask

  // one requester transaction: raise valid, wait for grant and ready, check data, release
  task automatic xact(input int id, input bit wr, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] er, output int g, output int r);
    int k = 0;
    g = -1;
    r = -1;
    @(negedge clk);
    if (wr) begin wa[id*8 +: 8] = a; wd[id*16 +: 16] = d; wv[id] = 1'b1; end
    else begin ra[id*8 +: 8] = a; rv[id] = 1'b1; end
    while (r < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (g < 0 && gid == id[1:0] && (wr ? mwv : mrv)) g = k;
      if (wr ? wrdy[id] : rrdy[id]) r = k;
    end
    chk("done_in_time", r >= 0, 1);
    chk("mem_vld_drop", wr ? mwv : mrv, 0);
    if (!wr) chk("rd_data", rdata[id*16 +: 16], er);
    if (wr) wv[id] = 1'b0; else rv[id] = 1'b0;
    @(negedge clk);
    chk("rdy_drop", wr ? wrdy[id] : rrdy[id], 0);
    if (!wr) chk("rd_data_hold", rdata[id*16 +: 16], er);
  endtask

  // memory model: ready pulse mem_lat cycles into each request while enabled
  initial forever begin
    @(negedge clk);
    mrr = 1'b0;
    mwr = 1'b0;
    if (mem_en && (mrv || mwv)) begin
      if (mcnt == mem_lat - 1) begin
        mcnt = 0;
        mrr = mrv;
        mwr = mwv;
        mrd = mem_fn(mra);
      end else mcnt++;
    end else mcnt = 0;
  end

  // grant monitor: pops the scoreboard on each new memory request and checks it is held
  initial forever begin
    @(negedge clk);
    if (reset) mv_q = 1'b0;
    else begin
      if ((mrv || mwv) && !mv_q) begin
        if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("gnt_id", gid, cur.id);
          chk("gnt_kind", mwv, cur.wr);
        end
      end
      if (mrv || mwv) begin
        chk("mem_addr", mwv ? mwa : mra, cur.addr);
        if (mwv) chk("mem_wdata", mwd, cur.wdata);
        chk("mem_excl", mrv & mwv, 0);
      end
      chk("stray_rdy", (rrdy | wrdy) & ~(4'b1 << gid), 0);
      mv_q = mrv || mwv;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, terr, mrv, mwv, rrdy, wrdy, gid, mra, mwa, mwd}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outs", {busy, terr, mrv, mwv, rrdy, wrdy, gid}, 0);
    chk("idle_data", rdata, 0);
    // fairness: everyone requests, rotation from requester 0
    push(0, 0, 8'h10, 0); push(1, 0, 8'h11, 0); push(2, 0, 8'h12, 0);
    push(3, 0, 8'h13, 0); push(0, 0, 8'h50, 0);
    fork
      begin
        xact(0, 0, 8'h10, 0, mem_fn(8'h10), lg[0], ld[0]);
        xact(0, 0, 8'h50, 0, mem_fn(8'h50), lg[0], ld[0]);
      end
      xact(1, 0, 8'h11, 0, mem_fn(8'h11), lg[1], ld[1]);
      xact(2, 0, 8'h12, 0, mem_fn(8'h12), lg[2], ld[2]);
      xact(3, 0, 8'h13, 0, mem_fn(8'h13), lg[3], ld[3]);
    join
    repeat (3) @(negedge clk);
    // single read with latency checks
    push(0, 0, 8'h12, 0);
    xact(0, 0, 8'h12, 0, 16'hBEEF, lg[0], ld[0]);
    chk("rd_grant_lat", lg[0], 1);
    chk("rd_done_lat", ld[0] - lg[0], 3);
    repeat (3) @(negedge clk);
    // read and write from one requester: read first, write next round
    push(1, 0, 8'h21, 0); push(1, 1, 8'h40, 16'h1234);
    fork
      xact(1, 0, 8'h21, 0, mem_fn(8'h21), lg[1], ld[1]);
      xact(1, 1, 8'h40, 16'h1234, 0, lg[2], ld[2]);
    join
    chk("wr_after_rd", lg[2] > ld[1], 1);
    repeat (3) @(negedge clk);
    // watchdog: memory never answers
    chk("to_err_pre", terr, 0);
    mem_en = 1'b0;
    push(2, 0, 8'h77, 0);
    xact(2, 0, 8'h77, 0, 16'h0, lg[2], ld[2]);
    chk("to_lat", ld[2] - lg[2], 5);
    chk("to_err", terr, 1);
    mem_en = 1'b1;
    push(3, 0, 8'h30, 0);
    xact(3, 0, 8'h30, 0, mem_fn(8'h30), lg[3], ld[3]);
    chk("to_err_sticky", terr, 1);
    repeat (3) @(negedge clk);
    // reset while waiting on memory
    mem_en = 1'b0;
    push(2, 0, 8'h33, 0);
    @(negedge clk);
    ra[16 +: 8] = 8'h33;
    rv[2] = 1'b1;
    n = 0;
    while (!mrv && n < 20) begin @(negedge clk); n++; end
    chk("rst_pre_state", {mrv, busy, terr}, 3'b111);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outs", {busy, terr, mrv, mwv, rrdy, wrdy, gid, mra}, 0);
    chk("rst_async_data", rdata, 0);
    rv[2] = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push(0, 0, 8'h60, 0); push(3, 0, 8'h63, 0);
    fork
      xact(0, 0, 8'h60, 0, mem_fn(8'h60), lg[0], ld[0]);
      xact(3, 0, 8'h63, 0, mem_fn(8'h63), lg[3], ld[3]);
    join
    chk("post_rst_order", lg[0] < lg[3], 1);
    // write path disabled instance: write requests must be ignored
    @(negedge clk);
    b_wa[8 +: 8] = 8'h55;
    b_wd[16 +: 16] = 16'hCAFE;
    b_wv[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("we0_busy", b_busy, 0);
      chk("we0_wrdy", b_wrdy, 0);
      chk("we0_mem", {b_mwv, b_mrv, b_mwa, b_mwd, b_mra, b_rrdy, b_gid, b_terr}, 0);
    end
    chk("we0_rdata", b_rdata, 0);
    b_wv[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
